// File: rtl/lane_rr_arbiter.sv
// Round-robin arbiter: grants one of LANES packed input lanes a burst of beats on a shared valid/ready channel.
// Optional stall timeout: define LANE_ARB_TIMEOUT_EN to add the stall counter and the timeout_err port.
module lane_rr_arbiter #(
    parameter int LANES  = 4,
    parameter int DW     = 32,
    parameter int BW     = 3,
    parameter int TO_CYC = 16,
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LANES-1:0]    req,
    input  logic [LANES*BW-1:0] burst_len,
    input  logic [LANES*DW-1:0] in_data,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    output logic [LW-1:0]       out_lane,
    output logic [LANES-1:0]    gnt,
    output logic                busy,
    output logic                burst_done,
`ifdef LANE_ARB_TIMEOUT_EN
    output logic                timeout_err,
`endif
    output logic                dbg_state_o
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [LW-1:0]    ptr_q, ptr_d;
    logic [LW-1:0]    lane_q, lane_d;
    logic [LANES-1:0] gnt_q, gnt_d;
    logic [BW-1:0]    beats_q, beats_d;
    logic             done_q, done_d;

    logic [DW-1:0]    lane_word [LANES];
    logic [BW-1:0]    lane_len  [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_unpack
        assign lane_word[i] = in_data[LANES*DW-1-i*DW -: DW];
        assign lane_len[i]  = burst_len[i*BW +: BW];
    end

    logic [LW-1:0] arb_base, arb_idx, arb_win;
    logic          arb_any;

    // While bursting, the scan starts after the owner: that is the pointer the burst end will install.
    assign arb_base = (state_q == BURST) ? lane_q + LW'(1) : ptr_q;

    always_comb begin
        arb_any = 1'b0;
        arb_win = arb_base;
        arb_idx = arb_base;
        for (int k = LANES - 1; k >= 0; k--) begin
            arb_idx = arb_base + LW'(k);
            if (req[arb_idx]) begin
                arb_any = 1'b1;
                arb_win = arb_idx;
            end
        end
    end

    // Handshake: a beat moves on a rising edge with out_valid and out_ready both high; out_valid
    // tracks the owner's live request, so it falls without a beat only when that lane aborts.
    logic beat, burst_end, grant_now, to_hit;

    assign out_valid = (state_q == BURST) && req[lane_q];
    assign out_data  = out_valid ? lane_word[lane_q] : '0;
    assign beat      = out_valid && out_ready;

`ifdef LANE_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TO_CYC + 1);

    logic [SW-1:0] stall_q, stall_d;
    logic          terr_q, terr_d;
    logic          stalled;

    assign stalled = out_valid && !out_ready;
    assign to_hit  = stalled && (stall_q == SW'(TO_CYC - 1));
    assign stall_d = (stalled && !burst_end) ? stall_q + SW'(1) : '0;
    assign terr_d  = terr_q || to_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            stall_q <= stall_d;
            terr_q  <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lane_d    = lane_q;
        gnt_d     = gnt_q;
        beats_d   = beats_q;
        done_d    = 1'b0;
        burst_end = 1'b0;
        grant_now = 1'b0;
        case (state_q)
            IDLE: begin
                grant_now = arb_any;
            end
            BURST: begin
                if (!out_valid || to_hit) begin
                    burst_end = 1'b1;
                end else if (beat) begin
                    if (beats_q == '0) burst_end = 1'b1;
                    else               beats_d   = beats_q - BW'(1);
                end
                if (burst_end) begin
                    done_d    = 1'b1;
                    ptr_d     = lane_q + LW'(1);
                    grant_now = arb_any;
                    if (!arb_any) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant_now) begin
            state_d = BURST;
            lane_d  = arb_win;
            gnt_d   = LANES'(1) << arb_win;
            beats_d = lane_len[arb_win];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lane_q  <= '0;
            gnt_q   <= '0;
            beats_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lane_q  <= lane_d;
            gnt_q   <= gnt_d;
            beats_q <= beats_d;
            done_q  <= done_d;
        end
    end

    assign gnt         = gnt_q;
    assign out_lane    = lane_q;
    assign busy        = (state_q == BURST);
    assign burst_done  = done_q;
    assign dbg_state_o = state_q;

endmodule
